// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings
// and a small helper used by the top-level controller.
// Optional feature macro: MEM_PORT_ARB_TIMEOUT_EN (ack watchdog).
package mem_port_arbiter_pkg;

    localparam int ARB_STATE_LEN = 2;

    localparam logic [ARB_STATE_LEN-1:0] ARB_IDLE   = 2'd0;
    localparam logic [ARB_STATE_LEN-1:0] ARB_D_BUSY = 2'd1;
    localparam logic [ARB_STATE_LEN-1:0] ARB_D_DONE = 2'd2;
    localparam logic [ARB_STATE_LEN-1:0] ARB_I_BUSY = 2'd3;

    // Width of the ack watchdog counter.
    localparam int ARB_WAIT_CNT_W = 8;

    // True while a memory request is outstanding (waiting for mem_ack).
    function automatic logic arb_is_busy(input logic [ARB_STATE_LEN-1:0] s);
        return (s == ARB_D_BUSY) || (s == ARB_I_BUSY);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the arbiter: a registered request with a
// single-cycle ack that also qualifies the read data.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Arbiter side: issues requests, receives completion.
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    // Memory model side.
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter_inst_buffer.sv
// Fetched-instruction holding register. Keeps the instruction and its
// valid flag until the pipeline consumes it, and remembers that an
// in-flight fetch was made stale by a flush so its data is discarded.
module mem_port_arbiter_inst_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              freeze_i,
    input  logic              fetch_busy_i,  // a fetch is outstanding
    input  logic              fill_i,        // fetch data arrives this cycle
    input  logic              fetch_end_i,   // outstanding fetch finishes (ack or abort)
    input  logic [DATA_W-1:0] fill_data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              drop_q,  drop_d;

    // Flush beats a same-cycle fill; a fill only lands if the fetch was
    // not invalidated earlier; an unfrozen cycle consumes the instruction.
    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        drop_d  = drop_q;

        if (flush_i) begin
            valid_d = 1'b0;
        end else if (fill_i && !drop_q) begin
            valid_d = 1'b1;
            rdata_d = fill_data_i;
        end else if (valid_q && !freeze_i) begin
            valid_d = 1'b0;
        end

        if (fetch_end_i) begin
            drop_d = 1'b0;
        end else if (flush_i && fetch_busy_i) begin
            drop_d = 1'b1;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_o = valid_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM
// stage. Data accesses win over fetches; an outstanding fetch is never
// preempted. freeze holds the pipeline while a data access is pending.
// Optional feature macro: MEM_PORT_ARB_TIMEOUT_EN adds an ack watchdog
// and the sticky timeout_err output.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    // MEM stage side
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              freeze,
    // memory side
    mem_port_arbiter_if.master mem
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    logic [ARB_STATE_LEN-1:0] state_q, state_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]        d_rdata_q, d_rdata_d;

    logic d_req;
    logic timeout_hit;
    logic fetch_busy;
    logic fetch_fill;
    logic fetch_end;

    // A simultaneous load and store request is handled as a store.
    assign d_req = d_rd_en | d_wr_en;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    localparam logic [ARB_WAIT_CNT_W:0] WAIT_LIMIT = TIMEOUT_CYCLES[ARB_WAIT_CNT_W:0];

    logic [ARB_WAIT_CNT_W-1:0] wait_cnt_q;
    logic                      timeout_err_q;

    // Fires on the last allowed wait cycle if the memory still has not acked.
    assign timeout_hit = arb_is_busy(state_q) && !mem.mem_ack &&
                         (({1'b0, wait_cnt_q} + 1'b1) == WAIT_LIMIT);

    // Wait counter restarts from zero on every new request; error is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (arb_is_busy(state_q)) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // Without the watchdog the controller waits for mem_ack forever.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // Next-state and memory-side register updates.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (d_req) begin
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_we_d    = d_wr_en;
                    mem_req_d   = 1'b1;
                    state_d     = ARB_D_BUSY;
                end else if (if_req && !if_valid && !flush) begin
                    mem_addr_d = if_addr;
                    mem_we_d   = 1'b0;
                    mem_req_d  = 1'b1;
                    state_d    = ARB_I_BUSY;
                end
            end
            ARB_D_BUSY: begin
                if (mem.mem_ack) begin
                    if (!mem_we_q) begin
                        d_rdata_d = mem.mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = ARB_D_DONE;
                end else if (timeout_hit) begin
                    d_rdata_d = '0;
                    mem_req_d = 1'b0;
                    state_d   = ARB_D_DONE;
                end
            end
            ARB_D_DONE: begin
                state_d = ARB_IDLE;
            end
            ARB_I_BUSY: begin
                if (mem.mem_ack || timeout_hit) begin
                    mem_req_d = 1'b0;
                    state_d   = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and memory-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Pipeline hold: asserted in the same cycle a data request shows up,
    // released in the completion cycle so the pipeline advances exactly once.
    assign freeze = ((state_q == ARB_IDLE) && d_req) ||
                    (state_q == ARB_D_BUSY) ||
                    ((state_q == ARB_I_BUSY) && d_req);

    assign d_done   = (state_q == ARB_D_DONE);
    assign d_rdata  = d_rdata_q;
    assign if_stall = if_req & ~if_valid;

    assign fetch_busy = (state_q == ARB_I_BUSY);
    assign fetch_fill = fetch_busy && mem.mem_ack;
    assign fetch_end  = fetch_busy && (mem.mem_ack || timeout_hit);

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    mem_port_arbiter_inst_buffer #(
        .DATA_W (DATA_W)
    ) u_inst_buffer (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .freeze_i     (freeze),
        .fetch_busy_i (fetch_busy),
        .fill_i       (fetch_fill),
        .fetch_end_i  (fetch_end),
        .fill_data_i  (mem.mem_rdata),
        .valid_o      (if_valid),
        .rdata_o      (if_rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with
// hand-computed expectations, then randomized traffic, all checked every
// cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    // model access phases
    localparam int K_NONE  = 0;
    localparam int K_DATA  = 1;
    localparam int K_FIN   = 2;
    localparam int K_FETCH = 3;

    logic clk = 1'b0;
    logic rst;
    logic if_req, flush, d_rd_en, d_wr_en, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic if_valid, if_stall, d_done, freeze;
    logic [DW-1:0] if_rdata, d_rdata;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();
    assign mem_bus.mem_rdata = mem_rdata;
    assign mem_bus.mem_ack   = mem_ack;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(255)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .flush    (flush),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .if_stall (if_stall),
        .d_rd_en  (d_rd_en),
        .d_wr_en  (d_wr_en),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .freeze   (freeze),
        .mem      (mem_bus)
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    int          m_kind = K_NONE;
    bit          m_live = 0;
    logic        m_req = 0, m_we = 0, m_ivalid = 0, m_drop = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_drdata = 0, m_irdata = 0;

    // activity counters observed from the DUT
    int freeze_cnt = 0, req_cnt = 0, done_cnt = 0, we_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model for the current cycle, then advance the
    // model across the coming clock edge.
    task automatic model_step();
        logic dreq, frz, fill, old_valid;
        dreq = d_rd_en | d_wr_en;
        frz  = (m_kind == K_NONE && dreq) || (m_kind == K_DATA) ||
               (m_kind == K_FETCH && dreq);
        if (m_live) begin
            chk("freeze",    freeze,            frz);
            chk("d_done",    d_done,            m_kind == K_FIN);
            chk("if_stall",  if_stall,          if_req & ~m_ivalid);
            chk("if_valid",  if_valid,          m_ivalid);
            chk("if_rdata",  if_rdata,          m_irdata);
            chk("d_rdata",   d_rdata,           m_drdata);
            chk("mem_req",   mem_bus.mem_req,   m_req);
            chk("mem_we",    mem_bus.mem_we,    m_we);
            chk("mem_addr",  mem_bus.mem_addr,  m_addr);
            chk("mem_wdata", mem_bus.mem_wdata, m_wdata);
        end
        if (freeze === 1'b1) freeze_cnt++;
        if (mem_bus.mem_req === 1'b1) req_cnt++;
        if (mem_bus.mem_req === 1'b1 && mem_bus.mem_we === 1'b1) we_cnt++;
        if (d_done === 1'b1) done_cnt++;

        if (rst) begin
            m_live = 1; m_kind = K_NONE;
            m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_drdata = 0;
            m_ivalid = 0; m_irdata = 0; m_drop = 0;
        end else begin
            fill      = (m_kind == K_FETCH) && mem_ack;
            old_valid = m_ivalid;
            if (flush) m_ivalid = 0;
            else if (fill && !m_drop) begin m_ivalid = 1; m_irdata = mem_rdata; end
            else if (m_ivalid && !frz) m_ivalid = 0;
            if (fill) m_drop = 0;
            else if (flush && m_kind == K_FETCH) m_drop = 1;
            case (m_kind)
                K_NONE: begin
                    if (dreq) begin
                        m_addr = d_addr; m_wdata = d_wdata; m_we = d_wr_en;
                        m_req = 1; m_kind = K_DATA;
                    end else if (if_req && !old_valid && !flush) begin
                        m_addr = if_addr; m_we = 0; m_req = 1; m_kind = K_FETCH;
                    end
                end
                K_DATA: if (mem_ack) begin
                    if (!m_we) m_drdata = mem_rdata;
                    m_req = 0; m_kind = K_FIN;
                end
                K_FIN: m_kind = K_NONE;
                default: if (mem_ack) begin m_req = 0; m_kind = K_NONE; end
            endcase
        end
    endtask

    // One clock cycle: check on the falling edge, return just after the rise.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the request, hold off ack for k cycles, then ack.
    task automatic serve(input int k, input logic [31:0] data);
        int n;
        n = 0;
        while (mem_bus.mem_req !== 1'b1 && n < 20) begin tick(); n++; end
        chk("serve_req_seen", mem_bus.mem_req, 1'b1);
        repeat (k) tick();
        mem_ack = 1; mem_rdata = data;
        tick();
        mem_ack = 0; mem_rdata = $urandom;
    endtask

    initial begin
        int b_frz, b_req, b_done, b_we;
        rst = 1; if_req = 0; if_addr = 0; flush = 0; d_rd_en = 0; d_wr_en = 0;
        d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
        repeat (3) tick();
        chk("rst_mem_req",  mem_bus.mem_req, 1'b0);
        chk("rst_if_valid", if_valid,        1'b0);
        chk("rst_d_rdata",  d_rdata,         32'h0);
        chk("rst_d_done",   d_done,          1'b0);
        rst = 0;
        tick();

        // fetch only
        b_frz = freeze_cnt; b_req = req_cnt;
        if_req = 1; if_addr = 32'h10;
        serve(2, 32'hDEADBEEF);
        chk("fetch_valid", if_valid, 1'b1);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
        chk("fetch_req_cycles", req_cnt - b_req, 3);
        chk("fetch_freeze_cycles", freeze_cnt - b_frz, 0);
        if_req = 0;
        tick();
        chk("fetch_consumed", if_valid, 1'b0);

        // load
        b_frz = freeze_cnt; b_done = done_cnt;
        d_rd_en = 1; d_addr = 32'h40;
        serve(2, 32'h1234);
        chk("load_done", d_done, 1'b1);
        chk("load_rdata", d_rdata, 32'h1234);
        chk("load_freeze_low", freeze, 1'b0);
        d_rd_en = 0;
        tick();
        chk("load_freeze_cycles", freeze_cnt - b_frz, 4);
        chk("load_done_pulses", done_cnt - b_done, 1);
        chk("load_done_low", d_done, 1'b0);

        // store
        b_we = we_cnt;
        d_wr_en = 1; d_addr = 32'h44; d_wdata = 32'hA5A5;
        serve(1, 32'h5555AAAA);
        chk("store_done", d_done, 1'b1);
        chk("store_rdata_kept", d_rdata, 32'h1234);
        chk("store_we_cycles", we_cnt - b_we, 2);
        chk("store_addr", mem_bus.mem_addr, 32'h44);
        chk("store_wdata", mem_bus.mem_wdata, 32'hA5A5);
        d_wr_en = 0;
        tick();

        // collision: load arrives during fetch
        if_req = 1; if_addr = 32'h80;
        tick();
        chk("col_fetch_addr", mem_bus.mem_addr, 32'h80);
        d_rd_en = 1; d_addr = 32'h48;
        #1;
        chk("col_freeze_now", freeze, 1'b1);
        mem_ack = 1; mem_rdata = 32'h1111;
        tick();
        mem_ack = 0;
        chk("col_fetch_valid", if_valid, 1'b1);
        chk("col_fetch_rdata", if_rdata, 32'h1111);
        chk("col_idle_freeze", freeze, 1'b1);
        tick();
        chk("col_data_req", mem_bus.mem_req, 1'b1);
        chk("col_data_addr", mem_bus.mem_addr, 32'h48);
        chk("col_valid_held", if_valid, 1'b1);
        mem_ack = 1; mem_rdata = 32'h2222;
        tick();
        mem_ack = 0;
        chk("col_done", d_done, 1'b1);
        chk("col_rdata", d_rdata, 32'h2222);
        chk("col_valid_at_done", if_valid, 1'b1);
        if_req = 0; d_rd_en = 0;
        tick();
        chk("col_valid_consumed", if_valid, 1'b0);

        // flush during fetch
        if_req = 1; if_addr = 32'h90;
        tick();
        flush = 1;
        tick();
        flush = 0; if_addr = 32'hA0;
        tick();
        mem_ack = 1; mem_rdata = 32'h9999;
        tick();
        mem_ack = 0;
        chk("flush_valid_low", if_valid, 1'b0);
        tick();
        chk("flush_refetch_req", mem_bus.mem_req, 1'b1);
        chk("flush_refetch_addr", mem_bus.mem_addr, 32'hA0);
        mem_ack = 1; mem_rdata = 32'hA0A0;
        tick();
        mem_ack = 0;
        chk("flush_refetch_rdata", if_rdata, 32'hA0A0);
        if_req = 0;
        tick();

        // reset while a load is outstanding, then a late ack
        b_done = done_cnt;
        d_rd_en = 1; d_addr = 32'h50;
        tick();
        rst = 1;
        tick();
        rst = 0; d_rd_en = 0; mem_ack = 1; mem_rdata = 32'h7777;
        tick();
        mem_ack = 0;
        chk("rstmid_mem_req", mem_bus.mem_req, 1'b0);
        chk("rstmid_d_rdata", d_rdata, 32'h0);
        tick(); tick();
        chk("rstmid_no_done", done_cnt - b_done, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            if_req    = ($urandom_range(0, 3) != 0);
            if_addr   = {$urandom_range(0, 255), 2'b00};
            d_rd_en   = ($urandom_range(0, 4) == 0);
            d_wr_en   = ($urandom_range(0, 5) == 0);
            d_addr    = $urandom;
            d_wdata   = $urandom;
            mem_ack   = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            tick();
        end

        rst = 0; flush = 0; if_req = 0; d_rd_en = 0; d_wr_en = 0; mem_ack = 1;
        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
